// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the pc, fetches from combinational imem and queues {pc, instr} for decode
// Ports: clk, reset (sync, active-high); imem_addr/imem_instr memory side;
//   redirect_valid/redirect_pc/halt control; out_valid/out_ready/out_instr/out_pc decode side.
// Optional FETCH_PERF_CNT_EN adds fetch_count/flush_count outputs.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [31:0] r_pc;
  logic [31:0] r_q_pc [DEPTH];
  logic [31:0] r_q_instr [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic w_pop, w_push;
  always_comb begin
    out_valid = !reset && r_count != '0;
    out_pc = out_valid ? r_q_pc[r_rptr] : '0;
    out_instr = out_valid ? r_q_instr[r_rptr] : '0;
    imem_addr = reset ? RESET_PC : r_pc;
    w_pop = out_valid && out_ready;
    // a full queue can still accept a fetch when the head leaves the same cycle
    w_push = !reset && !redirect_valid && !halt && (r_count < FULL || w_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_q_pc[r_wptr] <= r_pc;
        r_q_instr[r_wptr] <= imem_instr;
        r_wptr <= r_wptr + 1'b1;
        r_pc <= r_pc + PC_STEP;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (w_push) fetch_count <= fetch_count + 32'd1;
      if (redirect_valid && r_count != '0) flush_count <= flush_count + 32'd1;
    end
  end
`endif
endmodule
